pc_next_unit: RTL and testbench
===============================

// Module: pc_next_unit
// PURPOSE
//  Fetch-stage program counter: holds PC_F, selects next PC (sequential, branch, j/jal, jr) and supplies PC+4 to IF/ID.
//  Consumer of the decode-stage PC+4 value; closes the loop the PC+4 adder opens.
//  Sits between hazard unit (stall), decode-stage branch compare (br_taken) and instruction memory (pc_f).
//  Flags out-of-range or misaligned fetch addresses for the exception/debug path.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC value loaded on reset
//  PC_MIN    32'h0000_3000  lowest legal fetch address (inclusive)
//  PC_MAX    32'h0000_6FFC  highest legal fetch address (inclusive)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-high reset
//  stall      in   1   hazard-unit freeze; PC holds while high
//  npc_op     in   2   00 seq, 01 branch, 10 j/jal, 11 jr
//  br_taken   in   1   decode-stage compare result; used only when npc_op==01
//  pc4_d      in   32  PC+4 of instruction in decode stage
//  imm16      in   16  branch offset field of decode instruction
//  index26    in   26  jump index field of decode instruction
//  jr_target  in   32  forwarded rs value for jr/jalr
//  pc_f       out  32  current fetch address (registered)
//  pc4_f      out  32  pc_f + 4, combinational from pc_f
//  fetch_vld  out  1   fetch address valid this cycle (registered)
//  pc_err     out  1   sticky illegal-fetch flag (registered)
// BEHAVIOUR
//  Reset (async, any time incl. mid-stall): pc_f=RESET_PC, fetch_vld=0, pc_err=0; state=BOOT.
//  States: BOOT -> RUN on first clk edge after reset deasserts (regardless of stall); RUN holds until reset.
//   BOOT: pc_f holds RESET_PC, fetch_vld=0; no redirect accepted.
//   RUN:  fetch_vld=1 every cycle.
//  Next-PC select in RUN (all arithmetic 32-bit, wraps mod 2^32, no carry out):
//   00 -> pc_f + 4
//   01 -> br_taken ? pc4_d + {{14{imm16[15]}}, imm16, 2'b00} : pc_f + 4
//   10 -> {pc4_d[31:28], index26, 2'b00}
//   11 -> jr_target (loaded unmodified, low bits not cleared)
//  Delay slot: redirect applies to pc_f of the next edge; the instruction already at pc_f (delay slot) is never squashed.
//  stall=1 in RUN: pc_f, fetch_vld, pc_err hold; npc_op/br_taken ignored that cycle (decode recomputes next cycle).
//  stall and redirect same cycle: stall wins; redirect takes effect on first edge with stall=0.
//  pc_err: set on edge where newly loaded pc_f has pc[1:0]!=0, or pc<PC_MIN, or pc>PC_MAX (unsigned);
//   sticky until reset; PC continues to update normally after set.
//  pc4_f = pc_f + 4 at all times incl. reset (RESET_PC+4); 32'hFFFF_FFFC -> 32'h0000_0000.
//  Latency: select inputs to pc_f = 1 cycle; no combinational path from inputs to pc_f/fetch_vld/pc_err.
//  X on npc_op during stall=1 or BOOT must not corrupt state.
// TESTING
//  T1 reset then release, npc_op=00, 4 clks -> pc_f 3000(vld=0),3004,3008,300C; pc4_f=pc_f+4.
//  T2 pc4_d=3010, imm16=FFFE, npc_op=01, br_taken=1 -> pc_f=3008; br_taken=0 -> pc_f=prev+4.
//  T3 pc4_d=3010, index26=0000C10, npc_op=10 -> pc_f=0000_3040; npc_op=11, jr_target=3100 -> 3100.
//  T4 stall=1 with npc_op=10 for 3 clks -> pc_f frozen; stall=0 -> jump target loaded next edge.
//  T5 jr_target=3002 -> pc_f=3002, pc_err=1; then npc_op=00 x2 -> pc_f 3006,300A, pc_err stays 1.
//  T6 jr_target=7000 -> pc_err=1; assert reset mid-cycle (async) -> pc_f=3000, pc_err=0, fetch_vld=0 immediately.

Source files
------------

// File: rtl/pc_next_unit.sv
// Fetch-stage program counter: holds pc_f, selects the next PC (sequential,
// branch, jump, register jump) and flags illegal fetch addresses.
module pc_next_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_MIN   = 32'h0000_3000,
  parameter logic [31:0] PC_MAX   = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] pc4_d,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] jr_target,
  output logic [31:0] pc_f,
  output logic [31:0] pc4_f,
  output logic        fetch_vld,
  output logic        pc_err
);

  localparam int unsigned PC_W = 32;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [PC_W-1:0]   npc;
  logic [PC_W-1:0]   br_off;
  logic [PC_W-1:0]   pc_d;
  logic              vld_d;
  logic              err_d;

  function automatic logic pc_illegal(input logic [PC_W-1:0] pc);
    pc_illegal = (pc[1:0] != 2'b00) || (pc < PC_MIN) || (pc > PC_MAX);
  endfunction

  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign pc4_f  = pc_f + PC_W'(4);

  // Candidate next PC; only consulted on a non-stalled RUN edge.
  always_comb begin
    npc = pc_f + PC_W'(4);
    case (npc_op)
      2'b01:   npc = br_taken ? (pc4_d + br_off) : (pc_f + PC_W'(4));
      2'b10:   npc = {pc4_d[31:28], index26, 2'b00};
      2'b11:   npc = jr_target;
      default: npc = pc_f + PC_W'(4);
    endcase
  end

  // Next-state and register updates; BOOT ignores redirects and stall.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_f;
    vld_d   = fetch_vld;
    err_d   = pc_err;
    case (state_q)
      BOOT: begin
        state_d = RUN;
        vld_d   = 1'b1;
      end
      RUN: begin
        vld_d = 1'b1;
        if (!stall) begin
          pc_d  = npc;
          err_d = pc_err | pc_illegal(npc);
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= BOOT;
      pc_f      <= RESET_PC;
      fetch_vld <= 1'b0;
      pc_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_f      <= pc_d;
      fetch_vld <= vld_d;
      pc_err    <= err_d;
    end
  end

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: each driven cycle pushes the expected
// pc_f/fetch_vld/pc_err, popped and compared one edge later.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [31:0] pc4_d;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] jr_target;
  logic [31:0] pc_f;
  logic [31:0] pc4_f;
  logic        fetch_vld;
  logic        pc_err;

  typedef struct packed {
    logic [31:0] pc;
    logic        vld;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pc_next_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .pc4_d     (pc4_d),
    .imm16     (imm16),
    .index26   (index26),
    .jr_target (jr_target),
    .pc_f      (pc_f),
    .pc4_f     (pc4_f),
    .fetch_vld (fetch_vld),
    .pc_err    (pc_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    logic [31:0] pc4_exp;
    pc4_exp = e.pc + 32'd4;
    check({tag, ".pc_f"}, pc_f, e.pc);
    check({tag, ".pc4_f"}, pc4_f, pc4_exp);
    check({tag, ".vld"}, 32'(fetch_vld), 32'(e.vld));
    check({tag, ".err"}, 32'(pc_err), 32'(e.err));
  endtask

  // Drive one cycle of decode inputs, push the expectation, compare after the edge.
  task automatic cycle(input string tag, input logic stl, input logic [1:0] op,
                       input logic br, input logic [31:0] p4d, input logic [15:0] imm,
                       input logic [25:0] idx, input logic [31:0] jr,
                       input logic [31:0] exp_pc, input logic exp_vld, input logic exp_err);
    exp_t e;
    stall = stl; npc_op = op; br_taken = br; pc4_d = p4d;
    imm16 = imm; index26 = idx; jr_target = jr;
    e.pc = exp_pc; e.vld = exp_vld; e.err = exp_err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      compare_outputs(tag, sb.pop_front());
    end
  endtask

  // Assert reset away from the clock edge and confirm it acts immediately.
  task automatic reset_pulse(input string tag);
    exp_t e;
    #2;
    reset = 1'b1;
    #1;
    e.pc = 32'h0000_3000; e.vld = 1'b0; e.err = 1'b0;
    compare_outputs(tag, e);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; stall = 1'b0; npc_op = 2'b00; br_taken = 1'b0;
    pc4_d = '0; imm16 = '0; index26 = '0; jr_target = '0;
    #12;
    e.pc = 32'h0000_3000; e.vld = 1'b0; e.err = 1'b0;
    compare_outputs("rst", e);
    reset = 1'b0;

    // T1: BOOT edge keeps RESET_PC and raises fetch_vld, then sequential fetch.
    cycle("t1_boot", 0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_3000, 1, 0);
    cycle("t1_s1",   0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_3004, 1, 0);
    cycle("t1_s2",   0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_3008, 1, 0);
    cycle("t1_s3",   0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_300C, 1, 0);

    // T2: backward branch taken, then not taken.
    cycle("t2_bt",   0, 2'b01, 1, 32'h0000_3010, 16'hFFFE, '0, '0, 32'h0000_3008, 1, 0);
    cycle("t2_bnt",  0, 2'b01, 0, 32'h0000_3010, 16'hFFFE, '0, '0, 32'h0000_300C, 1, 0);

    // T3: jump and register jump.
    cycle("t3_j",    0, 2'b10, 0, 32'h0000_3010, '0, 26'h0000C10, '0, 32'h0000_3040, 1, 0);
    cycle("t3_jr",   0, 2'b11, 0, '0, '0, '0, 32'h0000_3100, 32'h0000_3100, 1, 0);

    // T4: stall freezes pc_f even with a pending jump or X select.
    cycle("t4_st1",  1, 2'b10, 0, 32'h0000_3010, '0, 26'h0000C20, '0, 32'h0000_3100, 1, 0);
    cycle("t4_st2",  1, 2'bxx, 1'bx, 32'h0000_3010, '0, 26'h0000C20, '0, 32'h0000_3100, 1, 0);
    cycle("t4_st3",  1, 2'b10, 0, 32'h0000_3010, '0, 26'h0000C20, '0, 32'h0000_3100, 1, 0);
    cycle("t4_go",   0, 2'b10, 0, 32'h0000_3010, '0, 26'h0000C20, '0, 32'h0000_3080, 1, 0);

    // T5: misaligned jr sets sticky error, PC keeps advancing.
    cycle("t5_jr",   0, 2'b11, 0, '0, '0, '0, 32'h0000_3002, 32'h0000_3002, 1, 1);
    cycle("t5_s1",   0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_3006, 1, 1);
    cycle("t5_s2",   0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_300A, 1, 1);

    // Upper bound: PC_MAX legal, one word past it illegal; BOOT ignores redirect and stall.
    reset_pulse("rst2");
    cycle("b_boot",  1, 2'b11, 0, '0, '0, '0, 32'h0000_5000, 32'h0000_3000, 1, 0);
    cycle("b_max",   0, 2'b11, 0, '0, '0, '0, 32'h0000_6FFC, 32'h0000_6FFC, 1, 0);
    cycle("b_over",  0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_7000, 1, 1);

    // Lower bound and pc4_f wrap.
    reset_pulse("rst3");
    cycle("l_boot",  0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_3000, 1, 0);
    cycle("l_min",   0, 2'b11, 0, '0, '0, '0, 32'h0000_3000, 32'h0000_3000, 1, 0);
    cycle("l_under", 0, 2'b11, 0, '0, '0, '0, 32'h0000_2FFC, 32'h0000_2FFC, 1, 1);
    cycle("l_wrap",  0, 2'b11, 0, '0, '0, '0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 1);
    cycle("l_wrap2", 0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_0000, 1, 1);

    // T6: out-of-range jr, then asynchronous reset clears everything at once.
    reset_pulse("rst4");
    cycle("t6_boot", 0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_3000, 1, 0);
    cycle("t6_jr",   0, 2'b11, 0, '0, '0, '0, 32'h0000_7000, 32'h0000_7000, 1, 1);
    reset_pulse("t6_rst");
    cycle("t6_post", 0, 2'b00, 0, '0, '0, '0, '0, 32'h0000_3000, 1, 0);

    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
